// File: rtl/w0rm_alu_writeback_queue.sv
// Pairs ALU results with destination tags recorded at dispatch. It hands each pair to
// writeback in issue order, and back-pressures dispatch because the ALU cannot stall.
module w0rm_alu_writeback_queue #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_reg,
  output logic                      issue_ready,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_result_valid,
  input  logic [3:0]                alu_result_flags,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [3:0]                wb_flags,
  output logic                      error_orphan
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [REG_ADDR_WIDTH-1:0] tag_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem  [DEPTH];
  logic [3:0]                flags_mem [DEPTH];

  logic [PTR_W-1:0] tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0] res_wr_q, res_wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] tag_count_q, tag_count_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             error_orphan_q, error_orphan_d;

  logic [CNT_W-1:0] awaiting_s;
  logic             tag_push_s;
  logic             res_push_s;
  logic             orphan_s;
  logic             pop_s;

  // Both FIFOs pop together, so a single read pointer serves tag and result storage.
  assign issue_ready  = (tag_count_q != DEPTH_CNT);
  assign wb_valid     = (res_count_q != CNT_ZERO);
  assign wb_reg       = wb_valid ? tag_mem[rd_q]   : {REG_ADDR_WIDTH{1'b0}};
  assign wb_data      = wb_valid ? data_mem[rd_q]  : {DATA_WIDTH{1'b0}};
  assign wb_flags     = wb_valid ? flags_mem[rd_q] : 4'b0000;
  assign error_orphan = error_orphan_q;

  // Next-state computation for pointers, occupancy counts and the sticky orphan flag.
  always_comb begin
    awaiting_s     = tag_count_q - res_count_q;
    tag_push_s     = issue_valid && issue_ready;
    res_push_s     = alu_result_valid && (awaiting_s != CNT_ZERO);
    orphan_s       = alu_result_valid && (awaiting_s == CNT_ZERO);
    pop_s          = wb_valid && wb_ready;
    tag_wr_d       = tag_push_s ? (tag_wr_q + PTR_ONE) : tag_wr_q;
    res_wr_d       = res_push_s ? (res_wr_q + PTR_ONE) : res_wr_q;
    rd_d           = pop_s ? (rd_q + PTR_ONE) : rd_q;
    error_orphan_d = error_orphan_q || orphan_s;
    tag_count_d    = tag_count_q;
    res_count_d    = res_count_q;
    case ({tag_push_s, pop_s})
      2'b10:   tag_count_d = tag_count_q + CNT_ONE;
      2'b01:   tag_count_d = tag_count_q - CNT_ONE;
      default: tag_count_d = tag_count_q;
    endcase
    case ({res_push_s, pop_s})
      2'b10:   res_count_d = res_count_q + CNT_ONE;
      2'b01:   res_count_d = res_count_q - CNT_ONE;
      default: res_count_d = res_count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_wr_q       <= PTR_ZERO;
      res_wr_q       <= PTR_ZERO;
      rd_q           <= PTR_ZERO;
      tag_count_q    <= CNT_ZERO;
      res_count_q    <= CNT_ZERO;
      error_orphan_q <= 1'b0;
    end else begin
      tag_wr_q       <= tag_wr_d;
      res_wr_q       <= res_wr_d;
      rd_q           <= rd_d;
      tag_count_q    <= tag_count_d;
      res_count_q    <= res_count_d;
      error_orphan_q <= error_orphan_d;
    end
  end

  // Payload storage; contents are don't-care until the matching count covers them.
  always_ff @(posedge clk) begin
    if (tag_push_s) begin
      tag_mem[tag_wr_q] <= issue_reg;
    end
    if (res_push_s) begin
      data_mem[res_wr_q]  <= alu_result;
      flags_mem[res_wr_q] <= alu_result_flags;
    end
  end

endmodule

// File: tb/tb_w0rm_alu_writeback_queue.sv
// Directed and randomized bench for w0rm_alu_writeback_queue. Expected outputs come from
// a queue-based model of tags, results and the sticky orphan flag.
module tb_w0rm_alu_writeback_queue;

  localparam int DW = 8;
  localparam int RW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [RW-1:0] issue_reg = '0;
  logic          issue_ready;
  logic [DW-1:0] alu_result = '0;
  logic          alu_result_valid = 1'b0;
  logic [3:0]    alu_result_flags = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [RW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic [3:0]    wb_flags;
  logic          error_orphan;

  int checks = 0;
  int failures = 0;

  logic [RW-1:0]   m_tags [$];
  logic [DW+3:0]   m_res  [$];
  logic            m_orphan = 1'b0;

  w0rm_alu_writeback_queue #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid),
    .alu_result_flags(alu_result_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .wb_flags(wb_flags), .error_orphan(error_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic          exp_v;
    logic [RW-1:0] exp_reg;
    logic [DW+3:0] exp_res;
    exp_v = (m_res.size() != 0);
    exp_reg = '0;
    exp_res = '0;
    if (exp_v) begin
      exp_reg = m_tags[0];
      exp_res = m_res[0];
    end
    chk("wb_valid", 32'(wb_valid), 32'(exp_v));
    chk("wb_reg", 32'(wb_reg), 32'(exp_reg));
    chk("wb_data", 32'(wb_data), 32'(exp_res[DW-1:0]));
    chk("wb_flags", 32'(wb_flags), 32'(exp_res[DW+3:DW]));
    chk("issue_ready", 32'(issue_ready), 32'(m_tags.size() < D));
    chk("error_orphan", 32'(error_orphan), 32'(m_orphan));
  endtask

  // Check outputs, apply the current inputs to the model, then cross one rising edge.
  task automatic tick();
    int            awaiting;
    bit            ready;
    logic [RW-1:0] dt;
    logic [DW+3:0] dr;
    check_outputs();
    awaiting = m_tags.size() - m_res.size();
    ready = (m_tags.size() < D);
    if (m_res.size() != 0 && wb_ready) begin
      dt = m_tags.pop_front();
      dr = m_res.pop_front();
    end
    if (issue_valid && ready) m_tags.push_back(issue_reg);
    if (alu_result_valid) begin
      if (awaiting != 0) m_res.push_back({alu_result_flags, alu_result});
      else m_orphan = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_result_valid = 1'b0;
    wb_ready = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, checked immediately, released on a falling edge.
  task automatic do_reset();
    idle();
    #2;
    reset_n = 1'b0;
    m_tags.delete();
    m_res.delete();
    m_orphan = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic send_result(input logic [DW-1:0] d, input logic [3:0] f);
    alu_result_valid = 1'b1;
    alu_result = d;
    alu_result_flags = f;
  endtask

  initial begin
    // Single op round trip.
    @(posedge clk); #1;
    do_reset();
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_reg = 4'd3;
    tick();
    issue_valid = 1'b0;
    tick();
    send_result(8'h2A, 4'b0001);
    tick();
    alu_result_valid = 1'b0;
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_reg", 32'(wb_reg), 32'd3);
    chk("t1_wb_data", 32'(wb_data), 32'h2A);
    chk("t1_wb_flags", 32'(wb_flags), 32'd1);
    tick();
    chk("t1_empty", 32'(wb_valid), 32'd0);

    // Fill the tag FIFO, hold the head under back-pressure, then drain.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_reg = RW'(i);
      tick();
    end
    chk("t2_full_ready", 32'(issue_ready), 32'd0);
    issue_reg = 4'd5;
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_result(8'h10 + DW'(i), 4'($urandom_range(0, 15)));
      tick();
    end
    alu_result_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_reg", 32'(wb_reg), 32'd1);
      chk("t2_hold_data", 32'(wb_data), 32'h10);
      tick();
    end
    // Pop while full with a concurrent issue that must be ignored.
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_reg = 4'd7;
    tick();
    issue_valid = 1'b0;
    chk("t3_ready_after_pop", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_drained", 32'(wb_valid), 32'd0);
    issue_valid = 1'b1; issue_reg = 4'd9;
    tick();
    issue_valid = 1'b0;
    send_result(8'h55, 4'b1010);
    tick();
    alu_result_valid = 1'b0;
    chk("t3_next_reg", 32'(wb_reg), 32'd9);
    tick();

    // Orphan result sets a sticky error.
    do_reset();
    send_result(8'hEE, 4'b1111);
    tick();
    alu_result_valid = 1'b0;
    chk("t4_orphan", 32'(error_orphan), 32'd1);
    chk("t4_no_valid", 32'(wb_valid), 32'd0);
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_reg = 4'd2;
    tick();
    issue_valid = 1'b0;
    send_result(8'h01, 4'b0100);
    tick();
    alu_result_valid = 1'b0;
    tick();
    chk("t4_sticky", 32'(error_orphan), 32'd1);

    // Reset in the middle of traffic, then a stray result.
    do_reset();
    issue_valid = 1'b1; issue_reg = 4'd5;
    tick();
    issue_reg = 4'd6;
    tick();
    issue_valid = 1'b0;
    send_result(8'h77, 4'b0010);
    tick();
    alu_result_valid = 1'b0;
    chk("t5_pre_valid", 32'(wb_valid), 32'd1);
    do_reset();
    chk("t5_rst_valid", 32'(wb_valid), 32'd0);
    chk("t5_rst_ready", 32'(issue_ready), 32'd1);
    send_result(8'h33, 4'b0011);
    tick();
    alu_result_valid = 1'b0;
    chk("t5_stray_orphan", 32'(error_orphan), 32'd1);

    // Streaming: one issue and one writeback per cycle.
    do_reset();
    wb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue_valid = 1'b1; issue_reg = RW'(i);
      if (i > 0) send_result(DW'($urandom), 4'($urandom));
      chk("t6_ready", 32'(issue_ready), 32'd1);
      if (i >= 2) chk("t6_valid", 32'(wb_valid), 32'd1);
      tick();
    end
    idle();
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      issue_valid = 1'($urandom);
      issue_reg = RW'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      alu_result_valid = ((m_tags.size() - m_res.size()) != 0) && 1'($urandom);
      alu_result = DW'($urandom);
      alu_result_flags = 4'($urandom);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
